riscv_pipe_stage: RTL and testbench
===================================

Name: riscv_pipe_stage

Overview:
Parametrised pipeline stage register with a valid/ready handshake, synchronous flush and an optional skid entry. It is the general replacement for single-register PC and pipeline latches that use only an enable. It sits between any two core pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and between the core and the bus interfaces. With the skid entry enabled, backpressure (o_ready) is fully registered, so no combinational ready path crosses the stage.

Parameters:
WIDTH, `XLEN, payload width in bits (1..256).
RESET_VALUE, 0, value loaded into both payload registers on reset.
SKID, 1, 1 = two-entry stage with registered o_ready; 0 = single entry with combinational o_ready.

Ports:
i_clk  input  1  clock, rising edge.
i_rstn  input  1  reset, asynchronous, active-low.
i_flush  input  1  synchronous kill of all held entries (branch mispredict or trap).
i_valid  input  1  upstream payload valid.
o_ready  output  1  stage can accept a payload this cycle.
i_data  input  WIDTH  upstream payload.
o_valid  output  1  downstream payload valid.
i_ready  input  1  downstream accepts the payload this cycle.
o_data  output  WIDTH  downstream payload; always driven from the main register.
o_count  output  2  number of held entries (0..2).

Behaviour:
- Reset (async, i_rstn=0): o_valid=0; skid_valid=0; main and skid payload = RESET_VALUE; o_count=0; o_ready=1. Outputs are stable from the first edge after reset is released.
- Handshake: push = i_valid & o_ready; pop = o_valid & i_ready.
  - i_data is sampled only on push.
  - o_data must not change while o_valid=1 and i_ready=0.
  - i_valid may be withdrawn without penalty.
- Latency: one cycle. A payload pushed at edge N is on o_data with o_valid=1 after edge N.
- SKID=1 state machine (EMPTY, ONE, FULL). o_ready = !skid_valid, taken from a flop. o_count: EMPTY=0, ONE=1, FULL=2.
  - EMPTY, push -> ONE, main <= i_data.
  - ONE, push & pop -> ONE, main <= i_data.
  - ONE, push & !pop -> FULL, skid <= i_data, main held.
  - ONE, pop & !push -> EMPTY.
  - FULL, pop -> ONE, main <= skid. No push is possible in FULL (o_ready=0).
  - Any state with no push and no pop: hold.
- SKID=0: there is no skid register.
  - o_ready = !o_valid | i_ready (combinational).
  - A push loads main and sets o_valid.
  - A pop without a push clears o_valid.
  - o_count = {1'b0, o_valid}.
- Full throughput: one payload per cycle in both modes when i_ready is held at 1. No bubbles are inserted.
- Flush:
  - Takes priority over everything on the same edge.
  - Clears o_valid and skid_valid (-> EMPTY).
  - Any push in the same cycle is discarded.
  - A pop in the same cycle still counts at the consumer (downstream saw o_valid&i_ready before the edge).
  - Payload registers are not cleared.
  - In SKID=1, o_ready=1 on the cycle after the flush.
- Reset asserted mid-transfer: all state returns to reset values immediately, without waiting for a clock edge.
- No X propagation: o_valid and o_ready are never X after reset, even if i_data is X.
- Occupancy can never exceed 2. A push while FULL is impossible by construction; the bench asserts this.

Test Plan:
- Reset, then stream 8 words 0x1..0x8 with i_valid=1 and i_ready=1 -> o_data shows 0x1..0x8 on 8 consecutive cycles, one cycle after each push; o_count=1 throughout; o_ready never 0.
- SKID=1: push 0xA, 0xB with i_ready=0 -> o_count=2, o_ready=0, o_data holds 0xA. Raise i_ready -> pops 0xA then 0xB, o_ready=1 one cycle after the first pop.
- Flush in FULL holding 0xC, 0xD, with i_valid=1, i_data=0xE in the same cycle -> next cycle o_valid=0, o_count=0, o_ready=1. 0xE is never output.
- SKID=0, WIDTH=64: o_valid=1 and i_ready toggled 1,0,1 while i_valid=1 -> o_ready follows i_ready combinationally in the same cycle. Data order is preserved and nothing is duplicated.
- Assert i_rstn low asynchronously between edges while FULL -> o_valid=0, o_count=0, o_data=RESET_VALUE (e.g. 0x0000_0000, or 0x8000_0000 for a PC instance) before the next edge.
- Random valid/ready (50%) over 10k cycles against a reference FIFO model -> output sequence equals input sequence; no push is accepted while o_count=2.

Source files
------------

// File: rtl/riscv_pipe_stage.sv
// Valid/ready pipeline stage register with synchronous flush and optional skid entry.
// SKID=1 gives a two-entry stage with o_ready straight from a flop; SKID=0 is a single entry.
`ifndef XLEN
`define XLEN 32
`endif

module riscv_pipe_stage #(
   parameter int unsigned      WIDTH       = `XLEN,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter bit               SKID        = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_flush,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   output logic [1:0]       o_count
);

   logic             push;
   logic             pop;
   logic [WIDTH-1:0] main_reg;

   assign push   = i_valid & o_ready;
   assign pop    = o_valid & i_ready;
   assign o_data = main_reg;

   generate
      if (SKID) begin : g_skid
         // Bit 0 = main entry valid, bit 1 = skid entry valid, so outputs come straight off flops.
         typedef enum logic [1:0] {
            EMPTY = 2'b00,
            ONE   = 2'b01,
            FULL  = 2'b11
         } state_t;

         state_t           state_reg;
         state_t           state_next;
         logic [WIDTH-1:0] skid_reg;

         always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
               state_reg <= EMPTY;
            end else begin
               state_reg <= state_next;
            end
         end

         always_comb begin
            state_next = state_reg;
            if (i_flush) begin
               state_next = EMPTY;
            end else begin
               case (state_reg)
                  EMPTY: if (push) state_next = ONE;
                  ONE: begin
                     if (push && !pop) begin
                        state_next = FULL;
                     end else if (pop && !push) begin
                        state_next = EMPTY;
                     end
                  end
                  FULL: if (pop) state_next = ONE;
                  default: state_next = EMPTY;
               endcase
            end
         end

         always_comb begin
            o_valid = state_reg[0];
            o_ready = ~state_reg[1];
            o_count = {state_reg[1], state_reg[0] & ~state_reg[1]};
         end

         // A flushed push is dropped; payloads themselves are never cleared by flush.
         always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
               main_reg <= RESET_VALUE;
               skid_reg <= RESET_VALUE;
            end else if (!i_flush) begin
               if (state_reg == FULL) begin
                  if (pop) main_reg <= skid_reg;
               end else if (push) begin
                  if (state_reg == ONE && !pop) begin
                     skid_reg <= i_data;
                  end else begin
                     main_reg <= i_data;
                  end
               end
            end
         end
      end else begin : g_single
         logic valid_reg;
         logic valid_next;

         always_comb begin
            valid_next = valid_reg;
            if (i_flush) begin
               valid_next = 1'b0;
            end else if (push) begin
               valid_next = 1'b1;
            end else if (pop) begin
               valid_next = 1'b0;
            end
         end

         always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
               valid_reg <= 1'b0;
               main_reg  <= RESET_VALUE;
            end else begin
               valid_reg <= valid_next;
               if (push && !i_flush) main_reg <= i_data;
            end
         end

         always_comb begin
            o_valid = valid_reg;
            o_ready = ~valid_reg | i_ready;
            o_count = {1'b0, valid_reg};
         end
      end
   endgenerate

endmodule

// File: tb/tb_riscv_pipe_stage.sv
// Bench for riscv_pipe_stage: a 32-bit skid instance and a 64-bit single-entry instance,
// each checked against a FIFO scoreboard plus directed scenario tasks.
`timescale 1ns/1ps

module tb_riscv_pipe_stage;

   localparam logic [31:0] RV1 = 32'h8000_0000;
   localparam logic [63:0] RV0 = 64'h0;

   logic        clk = 1'b0;
   logic        rstn;

   logic        flush1, iv1, ir1, ov1, or1;
   logic [31:0] id1, od1;
   logic [1:0]  oc1;

   logic        flush0, iv0, ir0, ov0, or0;
   logic [63:0] id0, od0;
   logic [1:0]  oc0;

   int          errors = 0;
   int          checks = 0;
   bit          sb_en = 1'b0;
   bit          verbose = 1'b1;
   logic [31:0] q1[$];
   logic [63:0] q0[$];

   always #5 clk = ~clk;

   riscv_pipe_stage #(.WIDTH(32), .RESET_VALUE(RV1), .SKID(1'b1)) dut1 (
      .i_clk(clk), .i_rstn(rstn), .i_flush(flush1), .i_valid(iv1), .o_ready(or1),
      .i_data(id1), .o_valid(ov1), .i_ready(ir1), .o_data(od1), .o_count(oc1)
   );

   riscv_pipe_stage #(.WIDTH(64), .RESET_VALUE(RV0), .SKID(1'b0)) dut0 (
      .i_clk(clk), .i_rstn(rstn), .i_flush(flush0), .i_valid(iv0), .o_ready(or0),
      .i_data(id0), .o_valid(ov0), .i_ready(ir0), .o_data(od0), .o_count(oc0)
   );

   // Scoreboard for the skid instance: sampled mid-cycle, describes what the next edge does.
   always @(negedge clk) begin
      if (sb_en && rstn) begin
         checks++;
         if (oc1 !== 2'(q1.size())) begin
            errors++; $display("FAIL sb1_count: got %0d expected %0d", oc1, q1.size());
         end
         checks++;
         if (or1 !== (q1.size() < 2)) begin
            errors++; $display("FAIL sb1_ready: got %b expected %b (held %0d)", or1, q1.size() < 2, q1.size());
         end
         checks++;
         if (ov1 !== (q1.size() != 0)) begin
            errors++; $display("FAIL sb1_valid: got %b expected %b", ov1, q1.size() != 0);
         end
         if (ov1 === 1'b1 && ir1 === 1'b1) begin
            checks++;
            if (q1.size() == 0) begin
               errors++; $display("FAIL sb1_data: got %h expected nothing", od1);
            end else begin
               if (od1 !== q1[0]) begin
                  errors++; $display("FAIL sb1_data: got %h expected %h", od1, q1[0]);
               end else if (verbose) begin
                  $display("[%0t] skid  pop  %h", $time, od1);
               end
               void'(q1.pop_front());
            end
         end
         if (flush1) q1.delete();
         else if (iv1 && or1) q1.push_back(id1);
      end
   end

   always @(negedge clk) begin
      if (sb_en && rstn) begin
         checks++;
         if (oc0 !== 2'(q0.size())) begin
            errors++; $display("FAIL sb0_count: got %0d expected %0d", oc0, q0.size());
         end
         checks++;
         if (or0 !== ((q0.size() == 0) || ir0)) begin
            errors++; $display("FAIL sb0_ready: got %b expected %b", or0, (q0.size() == 0) || ir0);
         end
         if (ov0 === 1'b1 && ir0 === 1'b1) begin
            checks++;
            if (q0.size() == 0) begin
               errors++; $display("FAIL sb0_data: got %h expected nothing", od0);
            end else begin
               if (od0 !== q0[0]) begin
                  errors++; $display("FAIL sb0_data: got %h expected %h", od0, q0[0]);
               end else if (verbose) begin
                  $display("[%0t] single pop %h", $time, od0);
               end
               void'(q0.pop_front());
            end
         end
         if (flush0) q0.delete();
         else if (iv0 && or0) q0.push_back(id0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      iv1 = 1'b0; ir1 = 1'b1; flush1 = 1'b0; id1 = '0;
      iv0 = 1'b0; ir0 = 1'b1; flush0 = 1'b0; id0 = '0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      #2;
      checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL rst1_valid: got %b expected 0", ov1); end
      checks++; if (oc1 !== 2'd0) begin errors++; $display("FAIL rst1_count: got %0d expected 0", oc1); end
      checks++; if (or1 !== 1'b1) begin errors++; $display("FAIL rst1_ready: got %b expected 1", or1); end
      checks++; if (od1 !== RV1) begin errors++; $display("FAIL rst1_data: got %h expected %h", od1, RV1); end
      checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL rst0_valid: got %b expected 0", ov0); end
      checks++; if (or0 !== 1'b1) begin errors++; $display("FAIL rst0_ready: got %b expected 1", or0); end
      checks++; if (od0 !== RV0) begin errors++; $display("FAIL rst0_data: got %h expected %h", od0, RV0); end
      rstn = 1'b1;
      q1.delete(); q0.delete();
      sb_en = 1'b1;
      step();
   endtask

   task automatic test_stream();
      for (int k = 1; k <= 8; k++) begin
         iv1 = 1'b1; id1 = 32'(k); ir1 = 1'b1;
         iv0 = 1'b1; id0 = 64'(k); ir0 = 1'b1;
         @(negedge clk);
         if (k > 1) begin
            checks++;
            if (od1 !== 32'(k - 1) || oc1 !== 2'd1) begin
               errors++; $display("FAIL stream1: got data %h count %0d expected %h count 1", od1, oc1, k - 1);
            end
            checks++;
            if (od0 !== 64'(k - 1) || ov0 !== 1'b1) begin
               errors++; $display("FAIL stream0: got data %h valid %b expected %h valid 1", od0, ov0, k - 1);
            end
         end
         step();
      end
      idle();
      @(negedge clk);
      checks++;
      if (od1 !== 32'd8 || od0 !== 64'd8) begin
         errors++; $display("FAIL stream_last: got %h / %h expected 8", od1, od0);
      end
      step();
   endtask

   task automatic test_skid_full();
      ir1 = 1'b0; iv1 = 1'b1; id1 = 32'hA;
      step();
      id1 = 32'hB;
      step();
      iv1 = 1'b0;
      @(negedge clk);
      checks++;
      if (oc1 !== 2'd2 || or1 !== 1'b0 || od1 !== 32'hA) begin
         errors++; $display("FAIL skid_full: got count %0d ready %b data %h expected 2 0 a", oc1, or1, od1);
      end
      step();
      ir1 = 1'b1;
      step();
      @(negedge clk);
      checks++;
      if (od1 !== 32'hB || or1 !== 1'b1 || oc1 !== 2'd1) begin
         errors++; $display("FAIL skid_drain: got data %h ready %b count %0d expected b 1 1", od1, or1, oc1);
      end
      step();
      idle();
      step();
   endtask

   task automatic test_flush();
      ir1 = 1'b0; iv1 = 1'b1; id1 = 32'hC;
      step();
      id1 = 32'hD;
      step();
      id1 = 32'hE; flush1 = 1'b1;
      step();
      flush1 = 1'b0; iv1 = 1'b0;
      @(negedge clk);
      checks++;
      if (ov1 !== 1'b0 || oc1 !== 2'd0 || or1 !== 1'b1) begin
         errors++; $display("FAIL flush: got valid %b count %0d ready %b expected 0 0 1", ov1, oc1, or1);
      end
      ir1 = 1'b1;
      repeat (3) step();
      checks++;
      if (ov1 !== 1'b0) begin
         errors++; $display("FAIL flush_leak: got valid %b data %h expected no output", ov1, od1);
      end
      idle();
   endtask

   task automatic test_single_comb_ready();
      iv0 = 1'b1; id0 = 64'h1111_0000_0000_0001; ir0 = 1'b1;
      step();
      id0 = 64'h2222_0000_0000_0002; ir0 = 1'b1;
      #1;
      checks++; if (or0 !== 1'b1) begin errors++; $display("FAIL comb_ready_hi: got %b expected 1", or0); end
      step();
      id0 = 64'h3333_0000_0000_0003; ir0 = 1'b0;
      #1;
      checks++; if (or0 !== 1'b0) begin errors++; $display("FAIL comb_ready_lo: got %b expected 0", or0); end
      step();
      ir0 = 1'b1;
      #1;
      checks++; if (or0 !== 1'b1) begin errors++; $display("FAIL comb_ready_back: got %b expected 1", or0); end
      step();
      iv0 = 1'b0;
      repeat (2) step();
      checks++;
      if (q0.size() != 0 || ov0 !== 1'b0) begin
         errors++; $display("FAIL single_order: got %0d pending valid %b expected 0 0", q0.size(), ov0);
      end
      idle();
   endtask

   task automatic test_async_reset();
      ir1 = 1'b0; iv1 = 1'b1; id1 = 32'h0F0F_0001;
      step();
      id1 = 32'h0F0F_0002;
      step();
      iv1 = 1'b0;
      @(negedge clk);
      checks++; if (oc1 !== 2'd2) begin errors++; $display("FAIL areset_pre: got count %0d expected 2", oc1); end
      #2;
      rstn = 1'b0;
      #1;
      checks++;
      if (ov1 !== 1'b0 || oc1 !== 2'd0 || od1 !== RV1 || or1 !== 1'b1) begin
         errors++; $display("FAIL areset: got valid %b count %0d data %h ready %b expected 0 0 %h 1", ov1, oc1, od1, or1, RV1);
      end
      q1.delete(); q0.delete();
      idle();
      @(posedge clk);
      #3;
      rstn = 1'b1;
      step();
   endtask

   task automatic test_random();
      verbose = 1'b0;
      for (int c = 0; c < 10000; c++) begin
         iv1 = 1'($urandom_range(0, 1)); ir1 = 1'($urandom_range(0, 1));
         id1 = $urandom; flush1 = ($urandom_range(0, 99) < 3);
         iv0 = 1'($urandom_range(0, 1)); ir0 = 1'($urandom_range(0, 1));
         id0 = {$urandom, $urandom}; flush0 = ($urandom_range(0, 99) < 3);
         step();
      end
      idle();
      repeat (4) step();
      checks++;
      if (q1.size() != 0 || q0.size() != 0) begin
         errors++; $display("FAIL random_drain: got pending %0d / %0d expected 0 / 0", q1.size(), q0.size());
      end
      verbose = 1'b1;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_skid_full();
      test_flush();
      test_single_comb_ready();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
